// File: rtl/seq_delay_responder_if.sv
// Request/response bundle between a requester (master) and seq_delay_responder (slave).
interface seq_delay_responder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic [CNT_W-1:0] delay;
  int               max_range;
  logic             c;
  logic             busy;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] dly_lat;

  modport master (
    output a, delay, max_range,
    input  c, busy, full, overflow, dly_lat
  );

  modport slave (
    input  a, delay, max_range,
    output c, busy, full, overflow, dly_lat
  );
endinterface

// File: rtl/seq_delay_responder.sv
// Returns one pulse on c exactly d cycles after each accepted request on a,
// tracking up to DEPTH outstanding requests as expiry stamps in a FIFO.
module seq_delay_responder #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_delay_responder_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DLY_MAX = '1;

  logic [CNT_W-1:0] tm_q,      tm_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [OCC_W-1:0] occ_q,     occ_d;
  logic [CNT_W-1:0] fifo_q [DEPTH];
  logic [CNT_W-1:0] fifo_d [DEPTH];
  logic             c_q,       c_d;
  logic             busy_q,    busy_d;
  logic             full_q,    full_d;
  logic             ovf_q,     ovf_d;
  logic [CNT_W-1:0] dly_lat_q, dly_lat_d;

  logic [CNT_W-1:0] mx;
  logic [CNT_W-1:0] d_req;
  logic [CNT_W-1:0] d_use;
  logic             pop;
  logic             push;

  // Clamp max_range to 1..DLY_MAX, then the requested delay to 1..mx.
  always_comb begin
    mx    = CNT_W'(1);
    d_req = CNT_W'(1);
    if (bus.max_range < 1) begin
      mx = CNT_W'(1);
    end else if ($unsigned(bus.max_range) > 32'(DLY_MAX)) begin
      mx = DLY_MAX;
    end else begin
      mx = CNT_W'($unsigned(bus.max_range));
    end
    if (bus.delay == '0) begin
      d_req = CNT_W'(1);
    end else if (bus.delay > mx) begin
      d_req = mx;
    end else begin
      d_req = bus.delay;
    end
  end

  // Next state: timer, stamp push/pop, occupancy, sticky overflow, delay latch.
  // Stamps are stored relative to the next timer value so that a head equal
  // to tm+1 expires exactly d edges after its request; equality-only matching
  // makes timer wrap harmless since d never exceeds DLY_MAX.
  always_comb begin
    tm_d      = tm_q + CNT_W'(1);
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    ovf_d     = ovf_q;
    dly_lat_d = dly_lat_q;

    pop   = (occ_q != '0) && (fifo_q[rd_ptr_q] == tm_d);
    push  = bus.a && ((occ_q != OCC_W'(DEPTH)) || pop);
    d_use = (occ_q == '0) ? d_req : dly_lat_q;

    if (push) begin
      fifo_d[wr_ptr_q] = tm_d + d_use;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      if (occ_q == '0) begin
        dly_lat_d = d_req;
      end
    end
    if (bus.a && !push) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end

    c_d    = pop;
    busy_d = (occ_d != '0);
    full_d = (occ_d == OCC_W'(DEPTH));
  end

  // State and registered outputs; reset flushes all outstanding requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      tm_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      fifo_q    <= '{default: '0};
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dly_lat_q <= CNT_W'(1);
    end else begin
      tm_q      <= tm_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      fifo_q    <= fifo_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      dly_lat_q <= dly_lat_d;
    end
  end

  assign bus.c        = c_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_q;
  assign bus.overflow = ovf_q;
  assign bus.dly_lat  = dly_lat_q;
endmodule
